pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic inter-stage pipeline register: IF/ID, ID/EX, EX/MEM, MEM/WB all instantiate it.
//  Adds a valid/ready handshake, stall back-pressure, a flush-to-bubble input and an optional skid entry.
//  A bubble forces all control bits to 0, so RegWrite, MemRead and MemWrite are inactive.
//  Data bits (PC, ALUOut, RtData, register addresses) are carried but never zeroed except by reset.
// PARAMETERS
//  CTRL_W  4   control-field width (e.g. {RegWrite,MemRead,MemWrite} plus MemtoReg[1:0] = 5)
//  DATA_W  32  data-field width (concatenated payload, e.g. 32+32+32+5+5 = 106)
//  SKID    1   1: two-entry skid buffer, in_ready is registered; 0: single entry, in_ready is combinational
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  flush      in   1       synchronous kill of all held and incoming entries
//  in_valid   in   1       upstream stage has a valid instruction
//  in_ready   out  1       this stage can accept
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       downstream entry is valid
//  out_ready  in   1       downstream accepts; 0 = stall
//  out_ctrl   out  CTRL_W  control bits; 0 whenever out_valid = 0
//  out_data   out  DATA_W  payload; undefined-but-held while out_valid = 0
// BEHAVIOUR
//  Reset (async): main_v = skid_v = 0, out_ctrl = 0, out_data = 0, skid regs = 0; in_ready = 1 after release.
//  Transfer rules:
//   - accept  = in_valid & in_ready
//   - advance = ~main_v | out_ready
//  Latency is 1 cycle: an accepted entry appears on out_* at the next edge when advance = 1.
//  SKID=1:
//   - in_ready = ~skid_v (flop output, no combinational path from out_ready).
//   - On advance: main <= skid if skid_v, else in if accept, else bubble. skid_v <= 0 unless accept while skid was loading.
//   - On ~advance & accept: skid <= in, skid_v <= 1.
//   - Skid is full => in_ready = 0; at most 2 entries held; no entry is ever dropped or duplicated.
//   - Order is preserved: a skid entry always leaves before a new input.
//  SKID=0:
//   - in_ready = advance (combinational).
//   - main loads in on accept, else a bubble when advance.
//  Simultaneous accept and out transfer while full (SKID=1): main <= skid, skid <= in; skid_v stays 1.
//  flush (priority over all except reset):
//   - next edge main_v = skid_v = 0 and out_ctrl = 0.
//   - The entry accepted in the flush cycle is discarded; in_ready = 1 the following cycle.
//  flush together with out_ready: the current out entry is consumed downstream and nothing is replaced.
//  Reset asserted mid-stall: all entries are lost, with the same state as power-up.
//  Stall hold: while out_valid & ~out_ready, out_ctrl and out_data are bit-stable.
// STRUCTURE
//  pipe_pkg:
//   - localparams for the standard CTRL_W/DATA_W per stage.
//   - typedef-equivalent field offsets (RegWrite, MemRead, MemWrite, MemtoReg) so stages pack and unpack consistently.
//  One sub-module, pipe_entry_reg: valid flag plus ctrl/data flops with load, bubble and clear.
//  It is instantiated twice (main, skid) or once when SKID = 0. Handshake logic stays in the top.
// TESTING
//  1 Reset: reset=1 mid-traffic with SKID=1 -> out_valid=0, out_ctrl=0, out_data=0; in_ready=1 one cycle after release.
//  2 Streaming: out_ready=1, in_valid=1 with data 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles, lag 1 cycle, no gaps.
//  3 Stall/skid: hold out_ready=0 for 3 cycles during the stream (ctrl=5'b10011) ->
//    - in_ready falls after 2 entries are held.
//    - out_data is stable.
//    - After release, order 0x3,0x4,0x5 is intact with no loss or duplication.
//  4 Flush: flush=1 while the skid is full and in_valid=1 with data 0xAA ->
//    - next cycle out_valid=0 and out_ctrl=0.
//    - 0xAA never appears on out_data; in_ready=1.
//  5 Bubble: in_valid=0 with out_ready=1 -> out_ctrl=0 (RegWrite=MemWrite=0) and out_data holds its last value.
//  6 SKID=0 build: same stream as test 2 plus a stall -> in_ready tracks out_ready combinationally; contents match test 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and control-field layout for the inter-stage pipeline registers,
// so every stage packs and unpacks {RegWrite,MemRead,MemWrite,MemtoReg} identically.
package pipe_pkg;

    localparam int CTRL_W_STD    = 5;

    localparam int IFID_CTRL_W   = 1;
    localparam int IFID_DATA_W   = 64;
    localparam int IDEX_CTRL_W   = CTRL_W_STD;
    localparam int IDEX_DATA_W   = 32 + 32 + 32 + 5 + 5;
    localparam int EXMEM_CTRL_W  = CTRL_W_STD;
    localparam int EXMEM_DATA_W  = 32 + 32 + 5;
    localparam int MEMWB_CTRL_W  = CTRL_W_STD;
    localparam int MEMWB_DATA_W  = 32 + 32 + 5;

    localparam int CTRL_MEMTOREG_LSB = 0;
    localparam int CTRL_MEMTOREG_W   = 2;
    localparam int CTRL_MEMWRITE     = 2;
    localparam int CTRL_MEMREAD      = 3;
    localparam int CTRL_REGWRITE     = 4;

    function automatic logic [CTRL_W_STD-1:0] pack_ctrl(
        input logic       reg_write,
        input logic       mem_read,
        input logic       mem_write,
        input logic [1:0] mem_to_reg
    );
        logic [CTRL_W_STD-1:0] v;
        v = '0;
        v[CTRL_REGWRITE] = reg_write;
        v[CTRL_MEMREAD]  = mem_read;
        v[CTRL_MEMWRITE] = mem_write;
        v[CTRL_MEMTOREG_LSB +: CTRL_MEMTOREG_W] = mem_to_reg;
        return v;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus ctrl/data flops; load takes effect next edge.
// Clear and bubble drop valid and zero ctrl but leave data held; no backpressure of its own.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear || i_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready, flush-to-bubble and optional skid entry; 1-cycle latency.
// SKID=1 holds up to two entries with a registered in_ready; SKID=0 passes out_ready back combinationally.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              w_main_v;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_advance;
    logic              w_accept;
    logic              w_main_load;
    logic              w_main_bubble;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;

    assign w_advance = ~w_main_v | out_ready;
    assign w_accept  = in_valid & in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              w_skid_v;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;
            logic              w_skid_load;
            logic              w_skid_bubble;

            assign in_ready = ~w_skid_v;

            // Skid always drains into main before any new input, which keeps order.
            assign w_main_load    = w_advance & (w_skid_v | w_accept);
            assign w_main_bubble  = w_advance & ~w_skid_v & ~w_accept;
            assign w_main_ctrl_in = w_skid_v ? w_skid_ctrl : in_ctrl;
            assign w_main_data_in = w_skid_v ? w_skid_data : in_data;

            assign w_skid_load    = w_accept & (~w_advance | w_skid_v);
            assign w_skid_bubble  = w_advance & w_skid_v & ~w_accept;

            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk      (clk),
                .reset    (reset),
                .i_clear  (flush),
                .i_load   (w_skid_load),
                .i_bubble (w_skid_bubble),
                .i_ctrl   (in_ctrl),
                .i_data   (in_data),
                .o_valid  (w_skid_v),
                .o_ctrl   (w_skid_ctrl),
                .o_data   (w_skid_data)
            );
        end else begin : g_noskid
            assign in_ready       = w_advance;
            assign w_main_load    = w_accept;
            assign w_main_bubble  = w_advance & ~w_accept;
            assign w_main_ctrl_in = in_ctrl;
            assign w_main_data_in = in_data;
        end
    endgenerate

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (flush),
        .i_load   (w_main_load),
        .i_bubble (w_main_bubble),
        .i_ctrl   (w_main_ctrl_in),
        .i_data   (w_main_data_in),
        .o_valid  (w_main_v),
        .o_ctrl   (w_main_ctrl),
        .o_data   (w_main_data)
    );

    assign out_valid = w_main_v;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench driving a SKID=1 and a SKID=0 instance side by side with shared handshake inputs.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = 5;
    localparam int DW = 32;

    // Stall scenario, bit c = cycle c
    localparam logic [8:0] IV_MASK   = 9'b011111111;
    localparam logic [8:0] ORDY_MASK = 9'b111100011;
    localparam logic [8:0] RDY1_EXP  = 9'b111000111;
    localparam logic [8:0] RDY0_EXP  = 9'b111100011;
    localparam int EXP_DATA [0:8] = '{1, 2, 2, 2, 2, 3, 4, 5, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] d1_in_data, d0_in_data;
    logic          d1_in_ready, d1_out_valid, d0_in_ready, d0_out_valid;
    logic [CW-1:0] d1_out_ctrl, d0_out_ctrl;
    logic [DW-1:0] d1_out_data, d0_out_data;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d1_in_ready), .in_ctrl(in_ctrl), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(out_ready), .out_ctrl(d1_out_ctrl), .out_data(d1_out_data)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d0_in_ready), .in_ctrl(in_ctrl), .in_data(d0_in_data),
        .out_valid(d0_out_valid), .out_ready(out_ready), .out_ctrl(d0_out_ctrl), .out_data(d0_out_data)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; d1_in_data = '0; d0_in_data = '0;
        tick(); tick();
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_ctrl !== '0 || d1_out_data !== '0) begin
            n_err++;
            $display("FAIL reset_state_skid1 got v=%b c=%h d=%h exp v=0 c=0 d=0", d1_out_valid, d1_out_ctrl, d1_out_data);
        end
        n_vec++;
        if (d0_out_valid !== 1'b0 || d0_out_ctrl !== '0 || d0_out_data !== '0) begin
            n_err++;
            $display("FAIL reset_state_skid0 got v=%b c=%h d=%h exp v=0 c=0 d=0", d0_out_valid, d0_out_ctrl, d0_out_data);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (d1_in_ready !== 1'b1 || d0_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got skid1=%b skid0=%b exp 1", d1_in_ready, d0_in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = pack_ctrl(1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            d1_in_data = DW'(k);
            d0_in_data = DW'(k);
            #1;
            n_vec++;
            if (d1_in_ready !== 1'b1 || d0_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_in_ready k=%0d got skid1=%b skid0=%b exp 1", k, d1_in_ready, d0_in_ready);
            end
            tick();
            n_vec++;
            if (d1_out_valid !== 1'b1 || d1_out_data !== DW'(k) || d1_out_ctrl !== 5'b10000) begin
                n_err++;
                $display("FAIL stream_out_skid1 k=%0d got v=%b c=%b d=%h exp v=1 c=10000 d=%h", k, d1_out_valid, d1_out_ctrl, d1_out_data, k);
            end
            n_vec++;
            if (d0_out_valid !== 1'b1 || d0_out_data !== DW'(k) || d0_out_ctrl !== 5'b10000) begin
                n_err++;
                $display("FAIL stream_out_skid0 k=%0d got v=%b c=%b d=%h exp v=1 c=10000 d=%h", k, d0_out_valid, d0_out_ctrl, d0_out_data, k);
            end
        end
    endtask

    task automatic test_bubble();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_ctrl !== '0 || d1_out_data !== 32'h8) begin
            n_err++;
            $display("FAIL bubble_skid1 got v=%b c=%b d=%h exp v=0 c=00000 d=8", d1_out_valid, d1_out_ctrl, d1_out_data);
        end
        n_vec++;
        if (d0_out_valid !== 1'b0 || d0_out_ctrl !== '0 || d0_out_data !== 32'h8) begin
            n_err++;
            $display("FAIL bubble_skid0 got v=%b c=%b d=%h exp v=0 c=00000 d=8", d0_out_valid, d0_out_ctrl, d0_out_data);
        end
    endtask

    task automatic test_stall();
        int  nxt1, nxt0;
        logic acc1, acc0;
        logic [CW-1:0] exp_ctrl;
        nxt1 = 1;
        nxt0 = 1;
        for (int c = 0; c < 9; c++) begin
            in_valid   = IV_MASK[c];
            out_ready  = ORDY_MASK[c];
            in_ctrl    = IV_MASK[c] ? pack_ctrl(1'b1, 1'b0, 1'b0, 2'b11) : '0;
            d1_in_data = DW'(nxt1);
            d0_in_data = DW'(nxt0);
            #1;
            n_vec++;
            if (d1_in_ready !== RDY1_EXP[c]) begin
                n_err++;
                $display("FAIL stall_in_ready_skid1 c=%0d got %b exp %b", c, d1_in_ready, RDY1_EXP[c]);
            end
            n_vec++;
            if (d0_in_ready !== RDY0_EXP[c]) begin
                n_err++;
                $display("FAIL stall_in_ready_skid0 c=%0d got %b exp %b", c, d0_in_ready, RDY0_EXP[c]);
            end
            acc1 = in_valid & d1_in_ready;
            acc0 = in_valid & d0_in_ready;
            tick();
            if (acc1) nxt1++;
            if (acc0) nxt0++;
            exp_ctrl = IV_MASK[c] ? 5'b10011 : 5'b00000;
            n_vec++;
            if (d1_out_valid !== IV_MASK[c] || d1_out_data !== DW'(EXP_DATA[c]) || d1_out_ctrl !== exp_ctrl) begin
                n_err++;
                $display("FAIL stall_out_skid1 c=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                         c, d1_out_valid, d1_out_ctrl, d1_out_data, IV_MASK[c], exp_ctrl, EXP_DATA[c]);
            end
            n_vec++;
            if (d0_out_valid !== IV_MASK[c] || d0_out_data !== DW'(EXP_DATA[c]) || d0_out_ctrl !== exp_ctrl) begin
                n_err++;
                $display("FAIL stall_out_skid0 c=%0d got v=%b c=%b d=%h exp v=%b c=%b d=%h",
                         c, d0_out_valid, d0_out_ctrl, d0_out_data, IV_MASK[c], exp_ctrl, EXP_DATA[c]);
            end
        end
    endtask

    task automatic test_flush();
        in_ctrl   = pack_ctrl(1'b1, 1'b0, 1'b0, 2'b11);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d1_in_data = 32'h11; d0_in_data = 32'h11;
        tick();
        d1_in_data = 32'h22; d0_in_data = 32'h22;
        tick();
        d1_in_data = 32'hAA; d0_in_data = 32'hAA;
        flush = 1'b1;
        #1;
        n_vec++;
        if (d1_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_skid_full_ready got %b exp 0", d1_in_ready);
        end
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_ctrl !== '0 || d1_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full_skid1 got v=%b c=%b rdy=%b exp v=0 c=00000 rdy=1", d1_out_valid, d1_out_ctrl, d1_in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_ctrl !== '0 || d1_out_data !== 32'h11) begin
            n_err++;
            $display("FAIL flush_accept_skid1 got v=%b c=%b d=%h exp v=0 c=00000 d=11", d1_out_valid, d1_out_ctrl, d1_out_data);
        end
        n_vec++;
        if (d0_out_valid !== 1'b0 || d0_out_ctrl !== '0 || d0_out_data !== 32'h11) begin
            n_err++;
            $display("FAIL flush_accept_skid0 got v=%b c=%b d=%h exp v=0 c=00000 d=11", d0_out_valid, d0_out_ctrl, d0_out_data);
        end
        tick();
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_data !== 32'h11 || d1_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_after_skid1 got v=%b d=%h rdy=%b exp v=0 d=11 rdy=1", d1_out_valid, d1_out_data, d1_in_ready);
        end
    endtask

    task automatic test_reset_mid_stall();
        in_ctrl   = pack_ctrl(1'b1, 1'b0, 1'b1, 2'b00);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d1_in_data = 32'h44; d0_in_data = 32'h44;
        tick();
        d1_in_data = 32'h55; d0_in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (d1_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_pre_ready got %b exp 0", d1_in_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_ctrl !== '0 || d1_out_data !== '0 || d1_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_async_skid1 got v=%b c=%b d=%h rdy=%b exp v=0 c=0 d=0 rdy=1",
                     d1_out_valid, d1_out_ctrl, d1_out_data, d1_in_ready);
        end
        n_vec++;
        if (d0_out_valid !== 1'b0 || d0_out_ctrl !== '0 || d0_out_data !== '0) begin
            n_err++;
            $display("FAIL midreset_async_skid0 got v=%b c=%b d=%h exp v=0 c=0 d=0", d0_out_valid, d0_out_ctrl, d0_out_data);
        end
        tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if (d1_in_ready !== 1'b1 || d1_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release got rdy=%b v=%b exp rdy=1 v=0", d1_in_ready, d1_out_valid);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        d1_in_data = 32'h33; d0_in_data = 32'h33;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (d1_out_valid !== 1'b1 || d1_out_data !== 32'h33) begin
            n_err++;
            $display("FAIL midreset_new_entry got v=%b d=%h exp v=1 d=33", d1_out_valid, d1_out_data);
        end
        tick();
        n_vec++;
        if (d1_out_valid !== 1'b0 || d1_out_data !== 32'h33) begin
            n_err++;
            $display("FAIL midreset_skid_lost got v=%b d=%h exp v=0 d=33", d1_out_valid, d1_out_data);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_bubble();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1);
    end

endmodule
